// File: rtl/ft245_sync_ctrl.sv
// Synchronous FT245-style bus controller bridging the host FIFO bus to RX/TX valid-ready streams.
// All bus strobes are registered; stream handshakes complete on the edge where valid and ready are both high.

module ft245_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_dat,
  input  logic                     i_pop,
  input  logic                     i_peek_nxt,
  output logic [DATA_W-1:0]        o_peek,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wp;
  logic [AW:0]       r_rp;
  logic              w_push;
  logic              w_pop;

  assign o_count = r_wp - r_rp;
  assign w_push  = i_push && (o_count != DEPTH_C);
  assign w_pop   = i_pop && (o_count != '0);
  // Peek either the head or the entry behind it, so a pop can hand the successor on without a bubble.
  assign o_peek  = r_mem[r_rp[AW-1:0] + AW'(i_peek_nxt)];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + ONE_C;
      if (w_pop)  r_rp <= r_rp + ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_dat;
  end
endmodule

module ft245_sync_ctrl #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_MAX  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ft_rxfn,
  input  logic              ft_txen,
  input  logic [DATA_W-1:0] ft_din,
  output logic [DATA_W-1:0] ft_dout,
  output logic              ft_rdn,
  output logic              ft_wrn,
  output logic              ft_oen,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   RD_START_C = (AW+1)'(FIFO_DEPTH - 4);
  localparam logic [AW:0]   RD_STOP_C  = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [AW:0]   ONE_C      = (AW+1)'(1);
  localparam logic [BW-1:0] BURST_C    = BW'(BURST_MAX);

  typedef enum logic [2:0] {IDLE, RD_OE, RD, RD_END, WR} state_t;

  state_t            r_state;
  logic              r_rdn;
  logic              r_wrn;
  logic              r_oen;
  logic              r_pref_rd;
  logic [DATA_W-1:0] r_dout;
  logic [BW-1:0]     r_burst;

  logic [AW:0]       w_rx_cnt;
  logic [AW:0]       w_tx_cnt;
  logic [AW:0]       w_rx_cnt_nxt;
  logic [AW:0]       w_tx_cnt_nxt;
  logic [DATA_W-1:0] w_tx_peek;
  logic [BW-1:0]     w_burst_nxt;
  logic              w_rx_push;
  logic              w_rx_pop;
  logic              w_tx_push;
  logic              w_tx_pop;
  logic              w_rd_req;
  logic              w_wr_req;

  assign w_rx_push    = (r_state == RD) && !r_rdn && !ft_rxfn;
  assign w_rx_pop     = rx_valid && rx_ready;
  assign w_tx_push    = tx_valid && tx_ready;
  assign w_tx_pop     = (r_state == WR) && !r_wrn && !ft_txen;
  assign w_rx_cnt_nxt = w_rx_cnt + (AW+1)'(w_rx_push) - (AW+1)'(w_rx_pop);
  assign w_tx_cnt_nxt = w_tx_cnt + (AW+1)'(w_tx_push) - (AW+1)'(w_tx_pop);
  assign w_burst_nxt  = r_burst + BW'(1);
  assign w_rd_req     = !ft_rxfn && (w_rx_cnt <= RD_START_C);
  assign w_wr_req     = !ft_txen && (w_tx_cnt != '0);

  assign rx_valid = (w_rx_cnt != '0);
  assign tx_ready = (w_tx_cnt != DEPTH_C);
  assign ft_rdn   = r_rdn;
  assign ft_wrn   = r_wrn;
  assign ft_oen   = r_oen;
  assign ft_dout  = r_dout;

  ft245_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_rx_push),
    .i_dat      (ft_din),
    .i_pop      (w_rx_pop),
    .i_peek_nxt (1'b0),
    .o_peek     (rx_data),
    .o_count    (w_rx_cnt)
  );

  ft245_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_tx_push),
    .i_dat      (tx_data),
    .i_pop      (w_tx_pop),
    .i_peek_nxt (w_tx_pop),
    .o_peek     (w_tx_peek),
    .o_count    (w_tx_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rdn     <= 1'b1;
      r_wrn     <= 1'b1;
      r_oen     <= 1'b1;
      r_dout    <= '0;
      r_burst   <= '0;
      r_pref_rd <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_burst <= '0;
          if (w_rd_req && (!w_wr_req || r_pref_rd)) begin
            r_state   <= RD_OE;
            r_oen     <= 1'b0;
            r_pref_rd <= 1'b0;
          end else if (w_wr_req) begin
            r_state   <= WR;
            r_wrn     <= 1'b0;
            r_dout    <= w_tx_peek;
            r_pref_rd <= 1'b1;
          end
        end
        RD_OE: begin
          r_rdn   <= 1'b0;
          r_state <= RD;
        end
        RD: begin
          if (w_rx_push) r_burst <= w_burst_nxt;
          // Stop with two slots spare so a re-arbitrated burst always starts with headroom.
          if (ft_rxfn || (w_rx_cnt_nxt >= RD_STOP_C) || (w_rx_push && (w_burst_nxt == BURST_C))) begin
            r_rdn   <= 1'b1;
            r_state <= RD_END;
          end
        end
        RD_END: begin
          r_oen   <= 1'b1;
          r_state <= IDLE;
        end
        WR: begin
          if (ft_txen) begin
            r_wrn   <= 1'b1;
            r_state <= IDLE;
          end else if (w_tx_pop) begin
            r_burst <= w_burst_nxt;
            if ((w_tx_cnt_nxt == '0) || (w_burst_nxt == BURST_C)) begin
              r_wrn   <= 1'b1;
              r_state <= IDLE;
            end else begin
              // A lone entry being retired means the successor is the word being pushed right now.
              r_dout <= (w_tx_cnt == ONE_C) ? tx_data : w_tx_peek;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ft245_sync_ctrl.sv
// Bench for ft245_sync_ctrl: host bus model plus scoreboard queues for the RX stream and host-side writes.
module tb_ft245_sync_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        ft_rxfn;
  logic        ft_txen;
  logic [31:0] ft_din;
  logic [31:0] ft_dout;
  logic        ft_rdn;
  logic        ft_wrn;
  logic        ft_oen;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  logic [31:0] host_rx[$];
  logic [31:0] rx_exp[$];
  logic [31:0] host_exp[$];
  int host_lim = 0;
  int host_rd_cnt = 0;
  int host_wr_cnt = 0;

  ft245_sync_ctrl #(.DATA_W(32), .FIFO_DEPTH(8), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst), .ft_rxfn(ft_rxfn), .ft_txen(ft_txen), .ft_din(ft_din),
    .ft_dout(ft_dout), .ft_rdn(ft_rdn), .ft_wrn(ft_wrn), .ft_oen(ft_oen),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic pin(input int sel);
    case (sel)
      0: return ft_rdn;
      1: return ft_wrn;
      default: return ft_oen;
    endcase
  endfunction

  task automatic wait_pin(input int sel, input logic val, input int budget, input string name);
    int n = 0;
    while (pin(sel) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(pin(sel) === val), 32'd1);
  endtask

  task automatic push_tx(input logic [31:0] w);
    logic acc = 1'b0;
    int n = 0;
    tx_data = w;
    tx_valid = 1'b1;
    host_exp.push_back(w);
    while (!acc && n < 100) begin
      acc = tx_ready;
      @(negedge clk);
      n++;
    end
    check("tx_push_accept", 32'(acc), 32'd1);
  endtask

  // Host side of the bus: supplies read words, accepts writes up to host_lim.
  initial begin
    logic rd_x, wr_x;
    ft_rxfn = 1'b1;
    ft_txen = 1'b1;
    ft_din  = '0;
    forever begin
      @(negedge clk); #1;
      rd_x = mon_en && !ft_rdn && !ft_rxfn;
      wr_x = mon_en && !ft_wrn && !ft_txen;
      @(posedge clk); #1;
      if (rd_x && host_rx.size() > 0) begin
        void'(host_rx.pop_front());
        host_rd_cnt++;
      end
      if (wr_x && host_lim > 0) begin
        host_lim--;
        host_wr_cnt++;
      end
      ft_rxfn = (host_rx.size() == 0);
      ft_din  = (host_rx.size() > 0) ? host_rx[0] : 32'h0;
      ft_txen = (host_lim == 0);
    end
  end

  // Monitor: pops the scoreboards whenever the DUT completes a transfer.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (mon_en) begin
        if (rx_valid && rx_ready) begin
          if (rx_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_unexpected: got 0x%0h, expected no word", rx_data);
          end else check("rx_data", rx_data, rx_exp.pop_front());
        end
        if (!ft_wrn && !ft_txen) begin
          if (host_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL host_unexpected: got 0x%0h, expected no word", ft_dout);
          end else check("host_wr_data", ft_dout, host_exp.pop_front());
        end
        check("strobe_excl", 32'(!ft_wrn && !ft_rdn), 32'd0);
        check("oen_during_wr", 32'(!ft_wrn && !ft_oen), 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded time limit after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[3];
    int ng;
    logic prev_oen, prev_wrn;
    rst = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_rdn", 32'(ft_rdn), 32'd1);
    check("rst_wrn", 32'(ft_wrn), 32'd1);
    check("rst_oen", 32'(ft_oen), 32'd1);
    check("rst_dout", ft_dout, 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0; mon_en = 1'b1;
    @(negedge clk);

    // Read burst of five words
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_rx.push_back(32'h11 + i);
      rx_exp.push_back(32'h11 + i);
    end
    wait_pin(2, 1'b0, 20, "rd_oen_fall");
    check("rd_oe_rdn_high", 32'(ft_rdn), 32'd1);
    @(negedge clk);
    check("rd_rdn_low", 32'(ft_rdn), 32'd0);
    check("rd_oen_low", 32'(ft_oen), 32'd0);
    wait_pin(0, 1'b1, 40, "rd_rdn_rise");
    check("rd_end_oen_low", 32'(ft_oen), 32'd0);
    @(negedge clk);
    check("rd_end_oen_rise", 32'(ft_oen), 32'd1);
    for (int n = 0; n < 50 && rx_exp.size() != 0; n++) @(negedge clk);
    check("rd_drain", 32'(rx_exp.size()), 32'd0);

    // RX backpressure with twenty queued words
    rx_ready = 1'b0;
    host_rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      host_rx.push_back(32'h100 + i);
      rx_exp.push_back(32'h100 + i);
    end
    wait_pin(0, 1'b0, 20, "bp_rdn_fall");
    wait_pin(0, 1'b1, 40, "bp_rdn_rise");
    check("bp_burst_len", 32'(host_rd_cnt), 32'd6);
    repeat (10) @(negedge clk);
    check("bp_hold", 32'(host_rd_cnt), 32'd6);
    check("bp_rx_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    for (int n = 0; n < 400 && rx_exp.size() != 0; n++) @(negedge clk);
    check("bp_drain", 32'(rx_exp.size()), 32'd0);
    check("bp_host_empty", 32'(host_rx.size()), 32'd0);

    // Eight-word write burst
    for (int i = 0; i < 8; i++) push_tx(32'hA0 + i);
    tx_valid = 1'b0;
    check("wr_tx_full", 32'(tx_ready), 32'd0);
    host_lim = 8;
    wait_pin(1, 1'b0, 20, "wr_wrn_fall");
    ng = 0;
    for (int n = 0; n < 50 && ft_wrn == 1'b0; n++) begin
      ng++;
      @(negedge clk);
    end
    check("wr_burst_len", 32'(ng), 32'd8);
    check("wr_delivered", 32'(host_exp.size()), 32'd0);
    check("wr_tx_ready", 32'(tx_ready), 32'd1);

    // txen stall after three words
    for (int i = 0; i < 6; i++) push_tx(32'hB0 + i);
    tx_valid = 1'b0;
    host_wr_cnt = 0;
    host_lim = 3;
    repeat (15) @(negedge clk);
    check("stall_retired", 32'(host_wr_cnt), 32'd3);
    check("stall_wrn_high", 32'(ft_wrn), 32'd1);
    check("stall_held", 32'(host_exp.size()), 32'd3);
    host_lim = 3;
    for (int n = 0; n < 40 && host_exp.size() != 0; n++) @(negedge clk);
    check("stall_resume", 32'(host_exp.size()), 32'd0);

    // Contention: both directions requesting at once
    for (int i = 0; i < 8; i++) push_tx(32'hD0 + i);
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_rx.push_back(32'hE0 + i);
      rx_exp.push_back(32'hE0 + i);
    end
    host_lim = 8;
    grants = '{9, 9, 9};
    ng = 0;
    prev_oen = ft_oen;
    prev_wrn = ft_wrn;
    for (int n = 0; n < 200 && ng < 3; n++) begin
      @(negedge clk);
      if (prev_oen && !ft_oen) begin grants[ng] = 0; ng++; end
      else if (prev_wrn && !ft_wrn) begin grants[ng] = 1; ng++; end
      prev_oen = ft_oen;
      prev_wrn = ft_wrn;
    end
    check("arb_count", 32'(ng), 32'd3);
    check("arb_g0_read", 32'(grants[0]), 32'd0);
    check("arb_g1_write", 32'(grants[1]), 32'd1);
    check("arb_g2_read", 32'(grants[2]), 32'd0);
    for (int n = 0; n < 200 && (rx_exp.size() != 0 || host_exp.size() != 0); n++) @(negedge clk);
    check("arb_rx_drain", 32'(rx_exp.size()), 32'd0);
    check("arb_wr_drain", 32'(host_exp.size()), 32'd0);

    // Reset in the middle of a read burst
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) host_rx.push_back(32'hF0 + i);
    wait_pin(0, 1'b0, 20, "mid_rdn_fall");
    @(negedge clk);
    rst = 1'b1;
    host_rx.delete();
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rdn", 32'(ft_rdn), 32'd1);
    check("mid_rst_wrn", 32'(ft_wrn), 32'd1);
    check("mid_rst_oen", 32'(ft_oen), 32'd1);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_rx_quiet", 32'(rx_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
